// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single data-cache port between loads and stores, one transaction at a time
module dcache_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W = 13,
  parameter logic [TAG_W-1:0] RD_TAG = 13'b0_1_1_0000000000,
  parameter logic [TAG_W-1:0] WR_TAG = 13'b1_1_1_0000000000,
  parameter int MAX_WR_STREAK = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  output logic              rd_grant_out,
  output logic [DATA_W-1:0] rd_data_out,
  output logic              rd_done_out,
  input  logic              wr_req_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              wr_grant_out,
  output logic              wr_done_out,
  input  logic              kill_in,
  output logic              reqcyc_out,
  output logic [ADDR_W-1:0] req_out,
  output logic [DATA_W-1:0] reqdata_out,
  output logic [TAG_W-1:0]  reqtag_out,
  input  logic              reqack_in,
  input  logic              respcyc_in,
  input  logic [DATA_W-1:0] resp_in,
  output logic              respack_out,
  input  logic              writeack_in,
  output logic              busy_out,
  output logic              timeout_err_out
);
  typedef enum logic [2:0] {IDLE, REQ_RD, WAIT_RD, REQ_WR, WAIT_WR} state_t;
  localparam int STK_W = $clog2(MAX_WR_STREAK + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [STK_W-1:0] MAX_STK = STK_W'(MAX_WR_STREAK);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  state_t state, stateNext;
  logic [STK_W-1:0] streak;
  logic [CNT_W-1:0] wdCnt;
  logic drop, grantWr, grantRd, respTake, wrAck, rdKeep;
  always_comb begin
    stateNext = state;
    grantWr = 1'b0;
    grantRd = 1'b0;
    respTake = 1'b0;
    wrAck = 1'b0;
    if (!timeout_err_out)
      case (state)
        IDLE: begin
          grantWr = wr_req_in && (!rd_req_in || streak < MAX_STK);
          grantRd = !grantWr && rd_req_in && !kill_in;
          stateNext = grantWr ? REQ_WR : grantRd ? REQ_RD : IDLE;
        end
        REQ_RD: stateNext = reqack_in ? WAIT_RD : REQ_RD;
        WAIT_RD: begin
          respTake = respcyc_in;
          stateNext = respcyc_in ? IDLE : WAIT_RD;
        end
        REQ_WR: stateNext = reqack_in ? WAIT_WR : REQ_WR;
        WAIT_WR: begin
          wrAck = writeack_in;
          stateNext = writeack_in ? IDLE : WAIT_WR;
        end
        default: stateNext = IDLE;
      endcase
  end
  // a kill arriving in the same cycle as the response still drops it
  assign rdKeep = respTake && !drop && !kill_in;
  assign busy_out = state != IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      streak <= '0;
      wdCnt <= '0;
      drop <= 1'b0;
      rd_grant_out <= 1'b0;
      wr_grant_out <= 1'b0;
      rd_data_out <= '0;
      rd_done_out <= 1'b0;
      wr_done_out <= 1'b0;
      respack_out <= 1'b0;
      reqcyc_out <= 1'b0;
      req_out <= '0;
      reqdata_out <= '0;
      reqtag_out <= '0;
      timeout_err_out <= 1'b0;
    end else begin
      state <= stateNext;
      rd_grant_out <= grantRd;
      wr_grant_out <= grantWr;
      respack_out <= respTake;
      rd_done_out <= rdKeep;
      wr_done_out <= wrAck;
      reqcyc_out <= stateNext == REQ_RD || stateNext == REQ_WR;
      if (rdKeep) rd_data_out <= resp_in;
      if (grantWr || grantRd) begin
        req_out <= grantWr ? wr_addr_in : rd_addr_in;
        reqdata_out <= grantWr ? wr_data_in : '0;
        reqtag_out <= grantWr ? WR_TAG : RD_TAG;
      end
      if (grantWr) streak <= rd_req_in ? streak + 1'b1 : '0;
      else if (grantRd) streak <= '0;
      if (grantRd) drop <= 1'b0;
      else if ((state == REQ_RD || state == WAIT_RD) && kill_in) drop <= 1'b1;
      if (state == IDLE) wdCnt <= '0;
      else if (!timeout_err_out) wdCnt <= wdCnt + 1'b1;
      timeout_err_out <= timeout_err_out || (state != IDLE && wdCnt == WD_LAST);
    end
  end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed plan plus random traffic checked against a transaction-level model
module tb_dcache_port_arbiter;
  localparam int MAXS = 4;
  localparam int TMO = 1024;
  localparam logic [12:0] RD_TAG = 13'b0_1_1_0000000000;
  localparam logic [12:0] WR_TAG = 13'b1_1_1_0000000000;
  logic clk = 1'b0, reset = 1'b0;
  logic rd_req_in = 0, wr_req_in = 0, kill_in = 0, reqack_in = 0, respcyc_in = 0, writeack_in = 0;
  logic [63:0] rd_addr_in = '0, wr_addr_in = '0, wr_data_in = '0, resp_in = '0;
  logic rd_grant_out, rd_done_out, wr_grant_out, wr_done_out, reqcyc_out, respack_out, busy_out, timeout_err_out;
  logic [63:0] rd_data_out, req_out, reqdata_out;
  logic [12:0] reqtag_out;
  int checks = 0, errors = 0;
  // model: kind 0 none, 1 load, 2 store in flight
  int mKind, mStreak, mWd;
  bit mAcked, mDrop, mErr;
  logic eRdGrant, eWrGrant, eRespack, eRdDone, eWrDone, eReqcyc, eBusy, eErr;
  logic [63:0] eReq, eReqdata, eRdData;
  logic [12:0] eReqtag;

  dcache_port_arbiter dut (
    .clk(clk), .reset(reset),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .rd_grant_out(rd_grant_out),
    .rd_data_out(rd_data_out), .rd_done_out(rd_done_out),
    .wr_req_in(wr_req_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .wr_grant_out(wr_grant_out), .wr_done_out(wr_done_out), .kill_in(kill_in),
    .reqcyc_out(reqcyc_out), .req_out(req_out), .reqdata_out(reqdata_out), .reqtag_out(reqtag_out),
    .reqack_in(reqack_in), .respcyc_in(respcyc_in), .resp_in(resp_in), .respack_out(respack_out),
    .writeack_in(writeack_in), .busy_out(busy_out), .timeout_err_out(timeout_err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mKind = 0; mStreak = 0; mWd = 0; mAcked = 0; mDrop = 0; mErr = 0;
    {eRdGrant, eWrGrant, eRespack, eRdDone, eWrDone, eReqcyc, eBusy, eErr} = '0;
    eReq = '0; eReqdata = '0; eRdData = '0; eReqtag = '0;
  endtask

  task automatic modelStep();
    int oldKind = mKind;
    {eRdGrant, eWrGrant, eRespack, eRdDone, eWrDone} = '0;
    if (!mErr) begin
      if (mKind == 0) begin
        if (wr_req_in && (!rd_req_in || mStreak < MAXS)) begin
          mKind = 2; mAcked = 0; eWrGrant = 1;
          eReq = wr_addr_in; eReqdata = wr_data_in; eReqtag = WR_TAG;
          mStreak = rd_req_in ? mStreak + 1 : 0;
        end else if (rd_req_in && !kill_in) begin
          mKind = 1; mAcked = 0; mDrop = 0; eRdGrant = 1;
          eReq = rd_addr_in; eReqdata = '0; eReqtag = RD_TAG; mStreak = 0;
        end
      end else begin
        if (mKind == 1 && kill_in) mDrop = 1;
        if (!mAcked) mAcked = reqack_in;
        else if (mKind == 1 && respcyc_in) begin
          eRespack = 1; mKind = 0;
          if (!mDrop) begin eRdDone = 1; eRdData = resp_in; end
        end else if (mKind == 2 && writeack_in) begin
          eWrDone = 1; mKind = 0;
        end
      end
    end
    if (oldKind != 0) begin
      mWd++;
      if (mWd == TMO) mErr = 1;
    end else mWd = 0;
    eBusy = mKind != 0;
    eReqcyc = mKind != 0 && !mAcked;
    eErr = mErr;
  endtask

  task automatic checkAll();
    chk("rd_grant", rd_grant_out, eRdGrant);
    chk("wr_grant", wr_grant_out, eWrGrant);
    chk("rd_done", rd_done_out, eRdDone);
    chk("rd_data", rd_data_out, eRdData);
    chk("wr_done", wr_done_out, eWrDone);
    chk("respack", respack_out, eRespack);
    chk("reqcyc", reqcyc_out, eReqcyc);
    chk("req", req_out, eReq);
    chk("reqdata", reqdata_out, eReqdata);
    chk("reqtag", reqtag_out, eReqtag);
    chk("busy", busy_out, eBusy);
    chk("timeout", timeout_err_out, eErr);
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    int g;
    modelReset();
    @(negedge clk);
    checkAll();
    reset = 1;
    tick();
    // load with late response
    rd_req_in = 1; rd_addr_in = 64'h1000;
    tick();
    chk("t1_grant", rd_grant_out, 1);
    chk("t1_tag", reqtag_out, RD_TAG);
    chk("t1_addr", req_out, 64'h1000);
    rd_req_in = 0; reqack_in = 1;
    tick();
    chk("t1_cyc_drop", reqcyc_out, 0);
    reqack_in = 0;
    tick();
    respcyc_in = 1; resp_in = 64'hDEADBEEF;
    tick();
    chk("t1_done", rd_done_out, 1);
    chk("t1_data", rd_data_out, 64'hDEADBEEF);
    chk("t1_respack", respack_out, 1);
    respcyc_in = 0;
    tick();
    chk("t1_respack_once", respack_out, 0);
    // store with delayed reqack
    wr_req_in = 1; wr_addr_in = 64'h2000; wr_data_in = 64'h55;
    tick();
    wr_req_in = 0; wr_addr_in = 64'hFFFF; wr_data_in = 64'hAAAA;
    for (int c = 1; c <= 5; c++) begin
      chk("t2_cyc", reqcyc_out, 1);
      chk("t2_addr", req_out, 64'h2000);
      chk("t2_data", reqdata_out, 64'h55);
      chk("t2_tag", reqtag_out, WR_TAG);
      if (c == 5) reqack_in = 1;
      tick();
    end
    reqack_in = 0;
    chk("t2_cyc_drop", reqcyc_out, 0);
    tick();
    writeack_in = 1;
    tick();
    chk("t2_done", wr_done_out, 1);
    writeack_in = 0;
    tick();
    // starvation bound: both requesters always pending, acks immediate
    rd_req_in = 1; wr_req_in = 1; reqack_in = 1; respcyc_in = 1; writeack_in = 1; resp_in = 64'hA5A5;
    g = 0;
    for (int i = 0; i < 60 && g < 10; i++) begin
      tick();
      if (rd_grant_out || wr_grant_out) begin
        chk("t3_order", rd_grant_out, (g % 5 == 4) ? 1 : 0);
        g++;
      end
    end
    chk("t3_count", g, 10);
    rd_req_in = 0; wr_req_in = 0;
    tick(); tick();
    reqack_in = 0; respcyc_in = 0; writeack_in = 0;
    tick();
    // kill during WAIT_RD
    rd_req_in = 1; rd_addr_in = 64'h3000;
    tick();
    rd_req_in = 0; reqack_in = 1;
    tick();
    reqack_in = 0; kill_in = 1;
    tick();
    kill_in = 0; respcyc_in = 1; resp_in = 64'h1234;
    tick();
    chk("t4_respack", respack_out, 1);
    chk("t4_nodone", rd_done_out, 0);
    chk("t4_data_kept", rd_data_out, 64'hA5A5);
    respcyc_in = 0; wr_req_in = 1; wr_addr_in = 64'h4000; wr_data_in = 64'h77;
    tick();
    chk("t4_wr_grant", wr_grant_out, 1);
    wr_req_in = 0; reqack_in = 1;
    tick();
    reqack_in = 0; writeack_in = 1;
    tick();
    writeack_in = 0;
    tick();
    // watchdog
    wr_req_in = 1; wr_addr_in = 64'h5000;
    tick();
    wr_req_in = 0;
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("t5_not_yet", timeout_err_out, 0);
    tick();
    chk("t5_err", timeout_err_out, 1);
    reqack_in = 1; writeack_in = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_sticky", timeout_err_out, 1);
    chk("t5_frozen", reqcyc_out, 1);
    reqack_in = 0; writeack_in = 0;
    reset = 0;
    #1;
    modelReset();
    chk("t5_cleared", timeout_err_out, 0);
    @(negedge clk);
    checkAll();
    reset = 1;
    tick();
    // async reset in REQ_WR
    wr_req_in = 1; wr_addr_in = 64'h6000;
    tick();
    chk("t6_in_req", reqcyc_out, 1);
    wr_req_in = 0;
    reset = 0;
    #1;
    modelReset();
    chk("t6_cyc", reqcyc_out, 0);
    chk("t6_busy", busy_out, 0);
    @(negedge clk);
    checkAll();
    reset = 1; writeack_in = 1;
    tick();
    chk("t6_no_done", wr_done_out, 0);
    writeack_in = 0;
    tick();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rd_req_in = $urandom_range(0, 1);
      wr_req_in = ($urandom_range(0, 2) == 0);
      kill_in = ($urandom_range(0, 7) == 0);
      reqack_in = $urandom_range(0, 1);
      respcyc_in = $urandom_range(0, 1);
      writeack_in = $urandom_range(0, 1);
      rd_addr_in = {$urandom, $urandom};
      wr_addr_in = {$urandom, $urandom};
      wr_data_in = {$urandom, $urandom};
      resp_in = {$urandom, $urandom};
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Owns the core's single data-cache port and shares it between two requesters: load requests from the memory stage and store requests from the writeback stage.
- Serialises them onto the cache bus with one transaction outstanding at a time.
- Drives the reqcyc/req/reqdata/reqtag handshake and returns load data or store completion to the winning requester.
- Write-priority arbitration with a bounded write streak prevents load starvation; a watchdog flags a hung bus.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
TAG_W, 13, cache request tag width
RD_TAG, 13'b0_1_1_0000000000, tag driven for loads
WR_TAG, 13'b1_1_1_0000000000, tag driven for stores
MAX_WR_STREAK, 4, consecutive store grants allowed while a load waits
TIMEOUT, 1024, cycles in one transaction before timeout_err_out sets

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
rd_req_in  in  1  load request; held until rd_grant_out
rd_addr_in  in  ADDR_W  load address
rd_grant_out  out  1  one-cycle pulse; load accepted, address latched
rd_data_out  out  DATA_W  load data; valid when rd_done_out=1
rd_done_out  out  1  one-cycle pulse; load complete
wr_req_in  in  1  store request; held until wr_grant_out
wr_addr_in  in  ADDR_W  store address
wr_data_in  in  DATA_W  store data
wr_grant_out  out  1  one-cycle pulse; store accepted, address and data latched
wr_done_out  out  1  one-cycle pulse; writeack received
kill_in  in  1  pipeline flush
reqcyc_out  out  1  cache request valid
req_out  out  ADDR_W  cache request address
reqdata_out  out  DATA_W  cache write data
reqtag_out  out  TAG_W  cache request tag
reqack_in  in  1  cache accepted the request
respcyc_in  in  1  cache read response valid
resp_in  in  DATA_W  cache read data
respack_out  out  1  response consumed
writeack_in  in  1  store committed by cache
busy_out  out  1  state != IDLE
timeout_err_out  out  1  sticky watchdog error

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; streak counter, watchdog counter and kill-drop flag cleared.
- All outputs are registered.
- States: IDLE, REQ_RD, WAIT_RD, REQ_WR, WAIT_WR.
- IDLE, store grant: wr_req_in=1 and (rd_req_in=0 or streak<MAX_WR_STREAK).
  - Latch wr_addr_in and wr_data_in; pulse wr_grant_out; enter REQ_WR.
  - streak increments if rd_req_in=1, otherwise clears to 0.
- IDLE, load grant: otherwise, if rd_req_in=1 and kill_in=0.
  - Latch rd_addr_in; pulse rd_grant_out; streak=0; enter REQ_RD.
- REQ_x: reqcyc_out=1 with req_out, reqdata_out and reqtag_out stable (reqdata_out=0 for loads).
  - On the edge that samples reqack_in=1: reqcyc_out drops to 0 and the state moves to WAIT_x.
- WAIT_RD: on respcyc_in=1, capture resp_in into rd_data_out, pulse respack_out for one cycle, pulse rd_done_out, return to IDLE.
- WAIT_WR: on writeack_in=1, pulse wr_done_out and return to IDLE.
- writeack_in and respcyc_in arriving in any other state are ignored.
- Minimum latencies:
  - Load: rd_req_in at cycle 0, reqcyc_out at cycle 1; with reqack_in at 1 and respcyc_in at 2, rd_done_out is at cycle 3.
  - Store: same timing, with writeack_in at cycle 2 giving wr_done_out at cycle 3.
- Back-to-back: a new grant may be issued in the IDLE cycle following a done pulse. No grant is issued in the same cycle as a done pulse.
- kill_in:
  - In IDLE: blocks a load grant that cycle; store grants proceed.
  - In REQ_RD or WAIT_RD: sets the drop flag. The bus transaction completes normally (respack_out still pulses), but rd_done_out is suppressed and rd_data_out is not updated.
  - Stores are never cancelled.
- Watchdog: counts cycles spent outside IDLE and clears on entry to IDLE. When the count reaches TIMEOUT, timeout_err_out=1 (sticky until reset) and the state machine holds its state.
- Reset asserted mid-transaction: immediate return to IDLE with reqcyc_out=0. Outstanding responses after reset release are ignored because they arrive while in IDLE.

Test Plan:
1. Load: rd_req_in=1, addr 0x1000; reqack_in at cycle 1; respcyc_in at cycle 3 with resp_in 0xDEADBEEF -> reqtag_out=RD_TAG, rd_done_out pulses at cycle 4, rd_data_out=0xDEADBEEF, respack_out is a single pulse.
2. Store: addr 0x2000, data 0x55; reqack_in delayed to cycle 5; writeack_in at cycle 7 -> req_out and reqdata_out stable through cycles 1-5, reqtag_out=WR_TAG, wr_done_out pulses at cycle 8.
3. Starvation: wr_req_in and rd_req_in held high continuously; every transaction acks immediately -> exactly 4 store grants, then 1 load grant, then the pattern repeats.
4. Kill mid-load: kill_in pulsed during WAIT_RD -> respack_out still pulses, rd_done_out stays 0, the next store grant proceeds.
5. Watchdog: store issued, reqack_in never asserted -> timeout_err_out=1 after 1024 cycles outside IDLE; it stays 1 until reset goes low.
6. Async reset asserted in REQ_WR (no clock edge) -> reqcyc_out and busy_out drop to 0 immediately; a writeack_in after release produces no wr_done_out pulse.
